// File: rtl/prio_encoder_pipe.sv
// Two-stage pipelined priority encoder with valid/ready flow control,
// per-word LSB/MSB priority, zero/multi-hot flags and a saturating error counter.
module prio_encoder_pipe #(
  parameter int DIN_W   = 32,
  parameter int GROUP_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIN_W-1:0]         din,
  input  logic                     mode_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DIN_W)-1:0] dout,
  output logic                     dout_hit,
  output logic                     dout_multi,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int DOUT_W = $clog2(DIN_W);
  localparam int NGRP   = DIN_W / GROUP_W;
  localparam int LGW    = $clog2(GROUP_W);
  localparam int LW     = (GROUP_W > 1) ? LGW : 1;

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  logic [NGRP-1:0]         g_hit, g_multi;
  logic [NGRP-1:0][LW-1:0] g_idx;

  logic [NGRP-1:0]         s1_ghit, s1_gmulti;
  logic [NGRP-1:0][LW-1:0] s1_gidx;
  logic                    s1_msb;

  logic [DOUT_W-1:0] win_g;
  logic              nxt_hit, nxt_multi;
  logic [DOUT_W-1:0] nxt_dout;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: per-group scan; the first set bit seen in LSB mode is kept,
  // in MSB mode every later set bit overwrites the index.
  always_comb begin
    g_hit   = '0;
    g_multi = '0;
    g_idx   = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      for (int unsigned i = 0; i < GROUP_W; i++) begin
        if (din[g*GROUP_W + i]) begin
          if (g_hit[g]) g_multi[g] = 1'b1;
          if (!g_hit[g] || mode_msb) g_idx[g] = LW'(i);
          g_hit[g] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_ghit   <= '0;
      s1_gmulti <= '0;
      s1_gidx   <= '0;
      s1_msb    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ghit   <= g_hit;
        s1_gmulti <= g_multi;
        s1_gidx   <= g_idx;
        s1_msb    <= mode_msb;
      end
    end
  end

  // Stage 2: same priority scan across groups.
  always_comb begin
    win_g     = '0;
    nxt_hit   = 1'b0;
    nxt_multi = |s1_gmulti;
    for (int unsigned g = 0; g < NGRP; g++) begin
      if (s1_ghit[g]) begin
        if (nxt_hit) nxt_multi = 1'b1;
        if (!nxt_hit || s1_msb) win_g = DOUT_W'(g);
        nxt_hit = 1'b1;
      end
    end
    nxt_dout = (win_g << LGW) | DOUT_W'(s1_gidx[win_g]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      dout       <= '0;
      dout_hit   <= 1'b0;
      dout_multi <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        dout       <= nxt_dout;
        dout_hit   <= nxt_hit;
        dout_multi <= nxt_multi;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && (!dout_hit || dout_multi) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Randomized and directed bench for prio_encoder_pipe against a queue-based
// reference model; a second instance with CNT_W=2 exercises counter saturation.
module tb_prio_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mode_msb, out_ready, err_clr;
  logic [31:0] din;
  logic        in_ready, out_valid, dout_hit, dout_multi;
  logic [4:0]  dout;
  logic [15:0] err_cnt;
  logic        in_ready2, out_valid2, dout_hit2, dout_multi2;
  logic [4:0]  dout2;
  logic [1:0]  err_cnt2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int         acc;
    logic [4:0] idx;
    logic       hit;
    logic       multi;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ecnt;
  logic [1:0]  ecnt2;

  always #5 clk = ~clk;

  prio_encoder_pipe #(.DIN_W(32), .GROUP_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .mode_msb(mode_msb), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .dout_hit(dout_hit), .dout_multi(dout_multi), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  prio_encoder_pipe #(.DIN_W(32), .GROUP_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .din(din),
    .mode_msb(mode_msb), .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2),
    .dout_hit(dout_hit2), .dout_multi(dout_multi2), .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Lowest set bit via two's-complement isolation, highest via log2.
  function automatic exp_t ref_enc(input logic [31:0] d, input logic m);
    exp_t e;
    longint unsigned v, low;
    v = longint'(d);
    low = v & (~v + 1);
    e.acc   = 0;
    e.hit   = (d != 0);
    e.multi = ($countones(d) > 1);
    if (d == 0)  e.idx = 5'd0;
    else if (m)  e.idx = 5'($clog2(v + 1) - 1);
    else         e.idx = 5'($clog2(low));
    return e;
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic m,
                      input logic ordy, input logic clr, output logic accepted);
    logic exp_rdy, exp_ov, del;
    exp_t e;
    @(negedge clk);
    in_valid = v; din = d; mode_msb = m; out_ready = ordy; err_clr = clr;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + 2);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("out_valid2", 32'(out_valid2), 32'(exp_ov));
    if (exp_ov) begin
      check("dout", 32'(dout), 32'(q[0].idx));
      check("dout_hit", 32'(dout_hit), 32'(q[0].hit));
      check("dout_multi", 32'(dout_multi), 32'(q[0].multi));
      check("dout2", 32'(dout2), 32'(q[0].idx));
    end
    del = exp_ov && ordy;
    accepted = v && exp_rdy;
    if (clr) begin
      ecnt = '0; ecnt2 = '0;
    end else if (del && (!q[0].hit || q[0].multi)) begin
      if (ecnt != 16'hFFFF) ecnt++;
      if (ecnt2 != 2'b11) ecnt2++;
    end
    if (del) void'(q.pop_front());
    if (accepted) begin
      e = ref_enc(d, m);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("err_cnt", 32'(err_cnt), 32'(ecnt));
    check("err_cnt2", 32'(err_cnt2), 32'(ecnt2));
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_hit"}, 32'(dout_hit), 32'd0);
    check({tag, "_multi"}, 32'(dout_multi), 32'd0);
    check({tag, "_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 4))
      0: w = 32'h0;
      1: w = 32'h1 << $urandom_range(0, 31);
      2: w = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
      3: w = $urandom;
      default: w = $urandom & (32'hFF << (8 * $urandom_range(0, 3)));
    endcase
    return w;
  endfunction

  task automatic drain();
    logic a;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, a);
  endtask

  initial begin
    logic        a;
    logic [31:0] w6[6];
    int          k;
    rst = 1'b1; in_valid = 1'b0; din = '0; mode_msb = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    ecnt = '0; ecnt2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk); rst = 1'b0;

    // LSB and MSB single bits, then all one-hots in both modes back-to-back
    step(1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, a);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, a);
    drain();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 32; i++) step(1'b1, 32'h1 << i, 1'(m), 1'b1, 1'b0, a);
    drain();

    // Multi-hot in both modes, then an all-zero word
    step(1'b1, 32'h0001_0010, 1'b0, 1'b1, 1'b0, a);
    step(1'b1, 32'h0001_0010, 1'b1, 1'b1, 1'b0, a);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, a);
    drain();

    // Six-word stream against a five-cycle output stall
    for (int i = 0; i < 6; i++) w6[i] = 32'h3 << (i * 5);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, w6[k], 1'b1, 1'b0, 1'b0, a);
      if (a) k++;
    end
    while (k < 6) begin
      step(1'b1, w6[k], 1'b1, 1'b1, 1'b0, a);
      if (a) k++;
    end
    drain();

    // Counter saturation, then clear with a same-cycle error transfer
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, a);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, a);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, a);
    drain();

    // Randomized traffic with backpressure and occasional clears
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_word(), 1'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, a);
    drain();

    // Asynchronous reset between edges with two words in flight
    step(1'b1, 32'h0000_0F00, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 32'h0000_00F0, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, a);
    #2 rst = 1'b1;
    #1;
    check_zero("async_rst");
    q.delete(); ecnt = '0; ecnt2 = '0;
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    step(1'b1, 32'h0040_0000, 1'b0, 1'b1, 1'b0, a);
    drain();

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
